// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin arbiter and sequencer that shares one I2C
// master write engine among NREQ requesters. It grants one requester, latches
// that requester's address/sub-address/data, raises start and follows the
// master's ready handshake to done or to a timeout abort.
module i2c_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_sub,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_sub,
    output logic [7:0]        m_data,
    input  logic              m_ready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   cur;
    logic [CW-1:0]   timer;
    logic [PW-1:0]   win;
    logic            win_valid;
    logic [PW-1:0]   ptr_after;

    logic [6:0] addr_arr [NREQ];
    logic [7:0] sub_arr  [NREQ];
    logic [7:0] data_arr [NREQ];

    // Unpack the flat requester buses into per-requester fields.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[7*gi +: 7];
            assign sub_arr[gi]  = req_sub[8*gi +: 8];
            assign data_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Winner: first active request scanning upward from rr_ptr with wrap.
    always_comb begin
        int            idx;
        logic [PW-1:0] pos;
        idx       = 0;
        pos       = '0;
        win       = '0;
        win_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            pos = PW'(idx);
            if (!win_valid && req[pos]) begin
                win_valid = 1'b1;
                win       = pos;
            end
        end
    end

    // Pointer value once the current owner has finished (one past it, wrapping).
    assign ptr_after = (cur == PLAST) ? '0 : cur + PW'(1);

    // Transaction sequencer; every output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            busy    <= 1'b0;
            m_start <= 1'b0;
            m_addr  <= '0;
            m_sub   <= '0;
            m_data  <= '0;
            rr_ptr  <= '0;
            cur     <= '0;
            timer   <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    // A low ready here means the master is busy with someone
                    // else's traffic, so hold off granting.
                    if (win_valid && m_ready) begin
                        m_addr  <= addr_arr[win];
                        m_sub   <= sub_arr[win];
                        m_data  <= data_arr[win];
                        gnt     <= NREQ'(1) << win;
                        cur     <= win;
                        timer   <= '0;
                        m_start <= 1'b1;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        timer   <= '0;
                        state   <= RUN;
                    end else if (timer == TLAST) begin
                        err     <= NREQ'(1) << cur;
                        m_start <= 1'b0;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        rr_ptr  <= ptr_after;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                RUN: begin
                    if (m_ready) begin
                        done   <= NREQ'(1) << cur;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= ptr_after;
                        state  <= IDLE;
                    end else if (timer == TLAST) begin
                        err    <= NREQ'(1) << cur;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= ptr_after;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                default: begin
                    m_start <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
